// File: rtl/rgmii_pkg.sv
// Shared definitions for the RGMII transmit speed controller: speed codes,
// controller states, lane payload structs and request normalisation.
package rgmii_pkg;

    localparam logic [1:0] SPEED_10M  = 2'b00;
    localparam logic [1:0] SPEED_100M = 2'b01;
    localparam logic [1:0] SPEED_1G   = 2'b10;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        QUIET = 2'd2
    } tx_state_e;

    // One clk worth of values handed to the ODDR cells, plus the MAC enable
    typedef struct packed {
        logic       txc_d1;
        logic       txc_d2;
        logic [3:0] td_d1;
        logic [3:0] td_d2;
        logic       ctl_d1;
        logic       ctl_d2;
        logic       clk_en;
    } lane_t;

    // MAC nibble and control captured at a 10M/100M period boundary
    typedef struct packed {
        logic [3:0] nib;
        logic       en;
        logic       er;
    } hold_t;

    localparam lane_t LANE_RESET = '{
        txc_d1: 1'b1, txc_d2: 1'b0,
        td_d1:  4'h0, td_d2:  4'h0,
        ctl_d1: 1'b0, ctl_d2: 1'b0,
        clk_en: 1'b1
    };

    // The reserved code 2'b11 is run as gigabit
    function automatic logic [1:0] norm_speed(input logic [1:0] req);
        return (req == 2'b11) ? SPEED_1G : req;
    endfunction

endpackage

// File: rtl/rgmii_txc_div.sv
// Nibble-period counter for 10M/100M: yields the TXC phase and the
// end-of-period flag for both the current and the upcoming count.
module rgmii_txc_div #(
    parameter int unsigned DIV_100M = 5,
    parameter int unsigned DIV_10M  = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic div_sel_i,
    input  logic clr_i,
    output logic txc_phase_c_o,
    output logic next_end_c_o,
    output logic period_end_o
);

    localparam int unsigned DIV_MAX = (DIV_10M > DIV_100M) ? DIV_10M : DIV_100M;
    localparam int unsigned CNT_W   = ($clog2(DIV_MAX) > 6) ? $clog2(DIV_MAX) : 6;

    localparam logic [CNT_W-1:0] LAST_100M = CNT_W'(DIV_100M - 1);
    localparam logic [CNT_W-1:0] LAST_10M  = CNT_W'(DIV_10M - 1);
    localparam logic [CNT_W-1:0] HALF_100M = CNT_W'(DIV_100M / 2);
    localparam logic [CNT_W-1:0] HALF_10M  = CNT_W'(DIV_10M / 2);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last, half;
    logic             period_end_q;

    // Phase and end flags are taken from the next count so the top can
    // register them and stay aligned with the counter
    always_comb begin
        last = div_sel_i ? LAST_10M : LAST_100M;
        half = div_sel_i ? HALF_10M : HALF_100M;
        if (clr_i || (cnt_q >= last)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        txc_phase_c_o = (cnt_d >= half);
        next_end_c_o  = (cnt_d >= last);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            period_end_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            period_end_q <= next_end_c_o;
        end
    end

    assign period_end_o = period_end_q;

endmodule

// File: rtl/rgmii_tx_speed_ctrl.sv
// RGMII transmit engine with runtime 1G/100M/10M selection; speed changes
// wait for an idle period boundary and hold TXC low before taking effect.
module rgmii_tx_speed_ctrl
    import rgmii_pkg::*;
#(
    parameter int unsigned DIV_100M      = 5,
    parameter int unsigned DIV_10M       = 50,
    parameter int unsigned QUIET_CYCLES  = 8,
    parameter int unsigned DRAIN_TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] speed_req_i,
    output logic [1:0] speed_cur_o,
    output logic       switch_busy_o,
    output logic       switch_forced_o,
    input  logic [7:0] gmii_txd_i,
    input  logic       gmii_tx_en_i,
    input  logic       gmii_tx_er_i,
    output logic       gmii_clk_en_o,
    output logic       txc_d1_o,
    output logic       txc_d2_o,
    output logic [3:0] td_d1_o,
    output logic [3:0] td_d2_o,
    output logic       ctl_d1_o,
    output logic       ctl_d2_o
);

    localparam int unsigned TMR_MAX = (DRAIN_TIMEOUT > QUIET_CYCLES) ? DRAIN_TIMEOUT : QUIET_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] DRAIN_LAST = TMR_W'(DRAIN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] QUIET_LAST = TMR_W'(QUIET_CYCLES - 1);

    tx_state_e        state_q, state_d;
    logic [1:0]       speed_q, speed_d;
    logic             busy_q, busy_d;
    logic             forced_q, forced_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    hold_t            hold_q, hold_d;
    lane_t            lane_q, lane_d;

    logic [1:0] req_n;
    logic       is_1g;
    logic       boundary;
    logic       div_sel;
    logic       div_clr;
    logic       txc_phase;
    logic       next_end;
    logic       period_end;

    assign is_1g   = (speed_q == SPEED_1G);
    assign div_sel = (speed_q == SPEED_10M);
    assign div_clr = (state_q == QUIET) || is_1g;

    rgmii_txc_div #(
        .DIV_100M (DIV_100M),
        .DIV_10M  (DIV_10M)
    ) u_div (
        .clk           (clk),
        .rst           (rst),
        .div_sel_i     (div_sel),
        .clr_i         (div_clr),
        .txc_phase_c_o (txc_phase),
        .next_end_c_o  (next_end),
        .period_end_o  (period_end)
    );

    // Next state, capture and lane values; lanes are driven from the next state
    always_comb begin
        state_d  = state_q;
        speed_d  = speed_q;
        busy_d   = busy_q;
        forced_d = 1'b0;
        tmr_d    = tmr_q;
        hold_d   = hold_q;
        lane_d   = lane_q;
        req_n    = norm_speed(speed_req_i);
        boundary = is_1g || period_end;

        unique case (state_q)
            RUN: begin
                if (req_n != speed_q) begin
                    state_d = DRAIN;
                    busy_d  = 1'b1;
                    tmr_d   = '0;
                end
            end
            DRAIN: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (boundary && !gmii_tx_en_i) begin
                    state_d = QUIET;
                    tmr_d   = '0;
                end else if (tmr_q >= DRAIN_LAST) begin
                    state_d  = QUIET;
                    forced_d = 1'b1;
                    tmr_d    = '0;
                end
            end
            QUIET: begin
                tmr_d = tmr_q + TMR_W'(1);
                if (tmr_q >= QUIET_LAST) begin
                    state_d = RUN;
                    speed_d = req_n;
                    busy_d  = 1'b0;
                    tmr_d   = '0;
                end
            end
            default: state_d = RUN;
        endcase

        // The first period after a switch carries idle, not stale data
        if (state_q == QUIET) begin
            hold_d = '0;
        end else if (!is_1g && period_end) begin
            hold_d = '{nib: gmii_txd_i[3:0], en: gmii_tx_en_i, er: gmii_tx_er_i};
        end

        if (state_d == QUIET) begin
            lane_d.txc_d1 = 1'b0;
            lane_d.txc_d2 = 1'b0;
            lane_d.ctl_d1 = 1'b0;
            lane_d.ctl_d2 = 1'b0;
            lane_d.clk_en = 1'b0;
        end else if (speed_d == SPEED_1G) begin
            lane_d.txc_d1 = 1'b1;
            lane_d.txc_d2 = 1'b0;
            lane_d.td_d1  = gmii_txd_i[3:0];
            lane_d.td_d2  = gmii_txd_i[7:4];
            lane_d.ctl_d1 = gmii_tx_en_i;
            lane_d.ctl_d2 = gmii_tx_en_i ^ gmii_tx_er_i;
            lane_d.clk_en = 1'b1;
        end else begin
            lane_d.txc_d1 = txc_phase;
            lane_d.txc_d2 = txc_phase;
            lane_d.td_d1  = hold_d.nib;
            lane_d.td_d2  = hold_d.nib;
            lane_d.ctl_d1 = txc_phase ? (hold_d.en ^ hold_d.er) : hold_d.en;
            lane_d.ctl_d2 = lane_d.ctl_d1;
            lane_d.clk_en = next_end;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            speed_q  <= SPEED_1G;
            busy_q   <= 1'b0;
            forced_q <= 1'b0;
            tmr_q    <= '0;
            hold_q   <= '0;
            lane_q   <= LANE_RESET;
        end else begin
            state_q  <= state_d;
            speed_q  <= speed_d;
            busy_q   <= busy_d;
            forced_q <= forced_d;
            tmr_q    <= tmr_d;
            hold_q   <= hold_d;
            lane_q   <= lane_d;
        end
    end

    assign speed_cur_o     = speed_q;
    assign switch_busy_o   = busy_q;
    assign switch_forced_o = forced_q;
    assign gmii_clk_en_o   = lane_q.clk_en;
    assign txc_d1_o        = lane_q.txc_d1;
    assign txc_d2_o        = lane_q.txc_d2;
    assign td_d1_o         = lane_q.td_d1;
    assign td_d2_o         = lane_q.td_d2;
    assign ctl_d1_o        = lane_q.ctl_d1;
    assign ctl_d2_o        = lane_q.ctl_d2;

endmodule

// File: tb/tb_rgmii_tx_speed_ctrl.sv
// Randomised scoreboard bench for rgmii_tx_speed_ctrl against a period/phase
// reference model of the transmit rules.
module tb_rgmii_tx_speed_ctrl;

    localparam int unsigned D100 = 5;
    localparam int unsigned D10  = 50;
    localparam int unsigned QC   = 8;
    localparam int unsigned DT   = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] speed_req = 2'b10;
    logic [7:0] txd = 8'h00;
    logic       tx_en = 1'b0;
    logic       tx_er = 1'b0;

    logic [1:0] speed_cur;
    logic       switch_busy, switch_forced, gmii_clk_en;
    logic       txc_d1, txc_d2, ctl_d1, ctl_d2;
    logic [3:0] td_d1, td_d2;

    rgmii_tx_speed_ctrl #(
        .DIV_100M      (D100),
        .DIV_10M       (D10),
        .QUIET_CYCLES  (QC),
        .DRAIN_TIMEOUT (DT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .speed_req_i     (speed_req),
        .speed_cur_o     (speed_cur),
        .switch_busy_o   (switch_busy),
        .switch_forced_o (switch_forced),
        .gmii_txd_i      (txd),
        .gmii_tx_en_i    (tx_en),
        .gmii_tx_er_i    (tx_er),
        .gmii_clk_en_o   (gmii_clk_en),
        .txc_d1_o        (txc_d1),
        .txc_d2_o        (txc_d2),
        .td_d1_o         (td_d1),
        .td_d2_o         (td_d2),
        .ctl_d1_o        (ctl_d1),
        .ctl_d2_o        (ctl_d2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] speed;
        logic       busy;
        logic       forced;
        logic       clk_en;
        logic       txc1;
        logic       txc2;
        logic [3:0] td1;
        logic [3:0] td2;
        logic       ctl1;
        logic       ctl2;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: mode 0 running, 1 waiting for an idle boundary, 2 TXC quiet
    int         m_speed, m_mode, m_pos, m_drain_n, m_quiet_n;
    logic [3:0] m_nib;
    logic       m_en, m_er;
    exp_t       m_out;

    function automatic int period_of(input int sp);
        return (sp == 0) ? D10 : D100;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_speed = 2; m_mode = 0; m_pos = 0; m_drain_n = 0; m_quiet_n = 0;
        m_nib = 4'h0; m_en = 1'b0; m_er = 1'b0;
        m_out = '{speed: 2'b10, busy: 1'b0, forced: 1'b0, clk_en: 1'b1, txc1: 1'b1,
                  txc2: 1'b0, td1: 4'h0, td2: 4'h0, ctl1: 1'b0, ctl2: 1'b0};
    endtask

    // Advance one clk with the inputs now applied and queue the outputs the DUT owes
    task automatic model_step();
        int  nreq, per, nper;
        bit  at_end, was_quiet, hi, forced;
        forced    = 1'b0;
        nreq      = (speed_req == 2'b11) ? 2 : int'(speed_req);
        per       = period_of(m_speed);
        at_end    = (m_speed == 2) || (m_pos == per - 1);
        was_quiet = (m_mode == 2);

        if (was_quiet) begin
            m_nib = 4'h0; m_en = 1'b0; m_er = 1'b0;
        end else if (m_speed != 2 && m_pos == per - 1) begin
            m_nib = txd[3:0]; m_en = tx_en; m_er = tx_er;
        end
        m_pos = (was_quiet || m_speed == 2) ? 0 : (m_pos + 1) % per;

        case (m_mode)
            0: if (nreq != m_speed) begin m_mode = 1; m_drain_n = 0; end
            1: begin
                m_drain_n++;
                if (at_end && !tx_en) begin
                    m_mode = 2; m_quiet_n = 0;
                end else if (m_drain_n == DT) begin
                    m_mode = 2; m_quiet_n = 0; forced = 1'b1;
                end
            end
            default: begin
                m_quiet_n++;
                if (m_quiet_n == QC) begin m_mode = 0; m_speed = nreq; end
            end
        endcase

        m_out.speed  = 2'(m_speed);
        m_out.busy   = (m_mode != 0);
        m_out.forced = forced;
        if (m_mode == 2) begin
            m_out.txc1 = 1'b0; m_out.txc2 = 1'b0;
            m_out.ctl1 = 1'b0; m_out.ctl2 = 1'b0;
            m_out.clk_en = 1'b0;
        end else if (m_speed == 2) begin
            m_out.txc1 = 1'b1; m_out.txc2 = 1'b0;
            m_out.td1  = txd[3:0]; m_out.td2 = txd[7:4];
            m_out.ctl1 = tx_en; m_out.ctl2 = tx_en ^ tx_er;
            m_out.clk_en = 1'b1;
        end else begin
            nper = period_of(m_speed);
            hi   = (m_pos >= nper / 2);
            m_out.txc1 = hi; m_out.txc2 = hi;
            m_out.td1  = m_nib; m_out.td2 = m_nib;
            m_out.ctl1 = hi ? (m_en ^ m_er) : m_en;
            m_out.ctl2 = m_out.ctl1;
            m_out.clk_en = (m_pos == nper - 1);
        end
        q.push_back(m_out);
    endtask

    task automatic tick(input logic [1:0] req, input logic en, input logic er, input logic [7:0] d);
        @(negedge clk);
        speed_req = req; tx_en = en; tx_er = er; txd = d;
        model_step();
    endtask

    task automatic check_reset_vals();
        chk("rst_speed_cur", 8'(speed_cur), 8'h02);
        chk("rst_busy", 8'(switch_busy), 8'h00);
        chk("rst_forced", 8'(switch_forced), 8'h00);
        chk("rst_clk_en", 8'(gmii_clk_en), 8'h01);
        chk("rst_txc_d1", 8'(txc_d1), 8'h01);
        chk("rst_txc_d2", 8'(txc_d2), 8'h00);
        chk("rst_td_d1", 8'(td_d1), 8'h00);
        chk("rst_td_d2", 8'(td_d2), 8'h00);
        chk("rst_ctl_d1", 8'(ctl_d1), 8'h00);
        chk("rst_ctl_d2", 8'(ctl_d2), 8'h00);
    endtask

    // Asynchronous reset mid-cycle, then release on a falling edge
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_vals();
        repeat (2) @(negedge clk);
        q.delete();
        rst = 1'b0;
        model_reset();
        speed_req = 2'b10; tx_en = 1'b0; tx_er = 1'b0; txd = 8'h00;
        model_step();
    endtask

    // Monitor: every active edge out of reset must match the next queued expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
                end else begin
                    e = q.pop_front();
                    chk("speed_cur", 8'(speed_cur), 8'(e.speed));
                    chk("switch_busy", 8'(switch_busy), 8'(e.busy));
                    chk("switch_forced", 8'(switch_forced), 8'(e.forced));
                    chk("gmii_clk_en", 8'(gmii_clk_en), 8'(e.clk_en));
                    chk("txc_d1", 8'(txc_d1), 8'(e.txc1));
                    chk("txc_d2", 8'(txc_d2), 8'(e.txc2));
                    chk("td_d1", 8'(td_d1), 8'(e.td1));
                    chk("td_d2", 8'(td_d2), 8'(e.td2));
                    chk("ctl_d1", 8'(ctl_d1), 8'(e.ctl1));
                    chk("ctl_d2", 8'(ctl_d2), 8'(e.ctl2));
                end
            end
        end
    end

    initial begin
        logic [1:0] req;
        logic       en;
        int         burst;
        int         n;

        model_reset();
        repeat (2) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        model_step();

        // Gigabit, including the reserved speed code
        tick(2'b10, 1'b1, 1'b0, 8'hA5);
        for (int i = 0; i < 30; i++)
            tick(($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom));

        // Idle switch to 100M, then directed and random 100M traffic
        repeat (20) tick(2'b01, 1'b0, 1'b0, 8'h00);
        repeat (10) tick(2'b01, 1'b1, 1'b0, 8'h03);
        repeat (10) tick(2'b01, 1'b1, 1'b1, 8'h03);
        for (int i = 0; i < 100; i++)
            tick(2'b01, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

        // Request 10M during a 40-clk 100M frame, then a long 10M stretch
        repeat (40) tick(2'b00, 1'b1, 1'b0, 8'($urandom));
        repeat (30) tick(2'b00, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 1000; i++)
            tick(2'b00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 8'($urandom));

        // tx_en stuck high forces the switch after the drain timeout
        for (int i = 0; i < 100; i++)
            tick(2'b01, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom));

        // Request withdrawn before the quiet period ends: speed stays 100M
        repeat (10) tick(2'b10, 1'b1, 1'b0, 8'($urandom));
        repeat (30) tick(2'b01, 1'b0, 1'b0, 8'h00);

        // Reset in the middle of the quiet period
        n = 0;
        tick(2'b00, 1'b0, 1'b0, 8'h00);
        while (m_mode != 2 && n < 200) begin
            tick(2'b00, 1'b0, 1'b0, 8'h00);
            n++;
        end
        checks++;
        if (m_mode != 2) begin
            errors++;
            $display("FAIL quiet_wait: got no quiet period after %0d cycles", n);
        end
        repeat (3) tick(2'b00, 1'b0, 1'b0, 8'h00);
        do_reset();
        for (int i = 0; i < 20; i++)
            tick(2'b10, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));

        // Random soak: occasional speed requests over bursty frames
        req = 2'b10; en = 1'b0; burst = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) req = 2'($urandom_range(0, 3));
            if (burst == 0) begin
                en    = ~en;
                burst = $urandom_range(5, 120);
            end
            burst--;
            tick(req, en, 1'($urandom_range(0, 15) == 0), 8'($urandom));
        end

        repeat (3) tick(req, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        chk("scoreboard_drained", 8'(q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
